usb_tx_word: RTL and testbench



---
 rtl/usb_tx_word.sv | 89 ++++++++
 tb/tb_usb_tx_word.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/usb_tx_word.sv
// usb_tx_word: sends a 32-bit word as one NRZI, bit-stuffed USB packet (SYNC, 4 bytes, EOP).
module usb_tx_word #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        output_ready,
    input  logic [31:0] average_data,
    output logic        d_plus,
    output logic        d_minus,
    output logic        tx_busy,
    output logic        tx_done
);
    typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J, DONE} state_t;
    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [5:0]  bitn, bitn_n;
    logic [2:0]  ones, ones_n;
    logic [31:0] sr, sr_n;
    logic        line, line_n;
    logic        last, stuff, driving;
    assign last    = cnt == 8'(CLKS_PER_BIT - 1);
    assign stuff   = sr[0] && ones == 3'd5;
    assign driving = state inside {SYNC, DATA, STUFF};
    assign d_plus  = driving ? line : state != EOP_SE0;
    assign d_minus = driving && !line;
    assign tx_busy = !(state inside {IDLE, DONE});
    assign tx_done = state == DONE;
    // line: 1 = J, 0 = K; it only moves on the edge that enters a new bit
    always_comb begin
        state_n = state;
        bitn_n  = bitn;
        ones_n  = ones;
        sr_n    = sr;
        line_n  = line;
        cnt_n   = (state inside {IDLE, DONE} || last) ? 8'd0 : cnt + 8'd1;
        case (state)
            IDLE: if (output_ready) begin
                state_n = SYNC;
                bitn_n  = 6'd0;
                ones_n  = 3'd0;
                sr_n    = average_data;
                line_n  = 1'b0;
            end
            SYNC: if (last) begin
                ones_n  = bitn == 6'd7 ? ones + 3'd1 : 3'd0;
                state_n = bitn == 6'd7 ? DATA : SYNC;
                bitn_n  = bitn == 6'd7 ? 6'd0 : bitn + 6'd1;
                line_n  = (bitn == 6'd7 ? sr[0] : bitn == 6'd6) ? line : !line;
            end
            DATA: if (last) begin
                ones_n  = (sr[0] && !stuff) ? ones + 3'd1 : 3'd0;
                sr_n    = sr >> 1;
                bitn_n  = bitn + 6'd1;
                state_n = stuff ? STUFF : bitn == 6'd31 ? EOP_SE0 : DATA;
                line_n  = (!stuff && sr[1]) ? line : !line;
            end
            // bitn already counts consumed payload bits, so 32 means the stuff followed the last one
            STUFF: if (last) begin
                state_n = bitn == 6'd32 ? EOP_SE0 : DATA;
                line_n  = sr[0] ? line : !line;
            end
            EOP_SE0: if (last) begin
                state_n = bitn[0] ? EOP_J : EOP_SE0;
                bitn_n  = bitn + 6'd1;
            end
            EOP_J: if (last) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            cnt   <= '0;
            bitn  <= '0;
            ones  <= '0;
            sr    <= '0;
            line  <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bitn  <= bitn_n;
            ones  <= ones_n;
            sr    <= sr_n;
            line  <= line_n;
        end
    end
endmodule

// File: tb/tb_usb_tx_word.sv
// tb_usb_tx_word: per-cycle comparison of the bus against a packet-level model, plus literal timing pins.
module tb_usb_tx_word;
    localparam int CPB = 8;
    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic        output_ready = 1'b0;
    logic [31:0] average_data = '0;
    logic        d_plus, d_minus, tx_busy, tx_done;
    logic [3:0]  exp_q[$];
    bit          chk_on = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    usb_tx_word #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .n_rst(n_rst), .output_ready(output_ready), .average_data(average_data),
        .d_plus(d_plus), .d_minus(d_minus), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h want 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {d_plus,d_minus,tx_busy,tx_done} per cycle, starting with the cycle after the accept edge.
    task automatic push_packet(input logic [31:0] d, output int stuffs);
        logic bits[$];
        logic lvl;
        int   run;
        for (int i = 0; i < 8; i++) bits.push_back(i == 7);
        for (int i = 0; i < 32; i++) bits.push_back(d[i]);
        lvl = 1'b1;
        run = 0;
        stuffs = 0;
        foreach (bits[i]) begin
            if (!bits[i]) lvl = !lvl;
            repeat (CPB) exp_q.push_back({lvl, !lvl, 2'b10});
            run = bits[i] ? run + 1 : 0;
            if (run == 6) begin
                lvl = !lvl;
                repeat (CPB) exp_q.push_back({lvl, !lvl, 2'b10});
                run = 0;
                stuffs++;
            end
        end
        repeat (2 * CPB) exp_q.push_back(4'b0010);
        repeat (CPB) exp_q.push_back(4'b1010);
        exp_q.push_back(4'b1001);
    endtask

    always @(negedge clk) begin
        logic [3:0] e;
        if (chk_on) begin
            e = 4'b1000;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            check("bus", {d_plus, d_minus, tx_busy, tx_done}, e);
        end
    end

    task automatic send(input logic [31:0] d, output time t_acc, output int stuffs);
        @(posedge clk);
        #1;
        average_data = d;
        output_ready = 1'b1;
        @(posedge clk);
        t_acc = $time;
        push_packet(d, stuffs);
        #1;
        output_ready = 1'b0;
        average_data = $urandom;
    endtask

    task automatic wait_done(input time t_acc, output int dur);
        dur = -1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (tx_done === 1'b1) begin
                dur = int'(($time - 5 - t_acc) / 10);
                break;
            end
        end
    endtask

    initial begin
        time t_acc;
        int  stuffs, dur;
        #2 n_rst = 1'b0;
        chk_on = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            output_ready = 1'($urandom);
            average_data = $urandom;
        end
        check("rst_dp", d_plus, 1);
        check("rst_dm", d_minus, 0);
        output_ready = 1'b0;
        n_rst = 1'b1;
        repeat (100) @(posedge clk);

        send(32'h0000_0000, t_acc, stuffs);
        check("stuff_zero", stuffs, 0);
        wait_done(t_acc, dur);
        check("dur_zero", dur, 344);

        send(32'hFFFF_FFFF, t_acc, stuffs);
        check("stuff_ones", stuffs, 5);
        wait_done(t_acc, dur);
        check("dur_ones", dur, 384);

        send(32'h0000_003F, t_acc, stuffs);
        check("stuff_3f", stuffs, 1);
        wait_done(t_acc, dur);
        check("dur_3f", dur, 352);

        send(32'hA5C3_0F7E, t_acc, stuffs);
        repeat (49) @(posedge clk);
        #1;
        output_ready = 1'b1;
        average_data = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        output_ready = 1'b0;
        wait_done(t_acc, dur);
        check("dur_ignored", dur, (43 + stuffs) * CPB);

        send(32'h1234_5678, t_acc, stuffs);
        #1;
        output_ready = 1'b1;
        average_data = 32'hFFFF_FFFF;
        wait_done(t_acc, dur);
        check("dur_held_a", dur, (43 + stuffs) * CPB);
        exp_q.push_back(4'b1000);
        @(posedge clk);
        @(posedge clk);
        t_acc = $time;
        push_packet(32'hFFFF_FFFF, stuffs);
        #1;
        output_ready = 1'b0;
        wait_done(t_acc, dur);
        check("dur_held_b", dur, 384);

        send(32'h0000_0000, t_acc, stuffs);
        repeat (227) @(posedge clk);
        #3;
        n_rst = 1'b0;
        exp_q.delete();
        #1;
        check("abort_bus", {d_plus, d_minus, tx_busy, tx_done}, 4'b1000);
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (50) @(posedge clk);
        send(32'hDEAD_BEEF, t_acc, stuffs);
        wait_done(t_acc, dur);
        check("dur_after_abort", dur, (43 + stuffs) * CPB);
        repeat (20) @(posedge clk);
        check("q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
